// File: rtl/mem_arb_pkg.sv
// Shared definitions for the three-way memory port arbiter.
//   - sel_t / SEL_REQx : encodings for the 3:1 operand mux select
//   - arb_state_e      : arbiter FSM states
//   - onehot_to_sel    : converts a one-hot grant into a mux select
//   - rr_next          : round-robin index arithmetic over three requesters
package mem_arb_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_REQ0 = 2'b00;
  localparam sel_t SEL_REQ1 = 2'b01;
  localparam sel_t SEL_REQ2 = 2'b10;

  localparam int unsigned NUM_REQ = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Zero or illegal multi-hot inputs map to SEL_REQ0; callers only pass
  // one-hot values, so the default is never observable on the port.
  function automatic sel_t onehot_to_sel(input logic [2:0] oh);
    sel_t s;
    unique case (oh)
      3'b010:  s = SEL_REQ1;
      3'b100:  s = SEL_REQ2;
      default: s = SEL_REQ0;
    endcase
    return s;
  endfunction

  // Requester index that is 'off' positions after 'last', modulo three.
  function automatic sel_t rr_next(input sel_t last, input int unsigned off);
    int unsigned s;
    s = 32'(last) + off;
    return 2'(s % NUM_REQ);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the arbiter and its environment.
//   req_i       : per-requester level request
//   bus_ready_i : shared port completes the current transfer this cycle
//   grant_o     : one-hot registered grant
//   sel_o       : operand mux select
//   bus_valid_o : transfer active on the shared port
//   ack_o       : grant qualified by bus_ready_i
//   abort_o     : grant qualified by the watchdog expiring
// Modport 'master' is the arbiter side, 'slave' the requester/bus side.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic [2:0] req_i;
  logic       bus_ready_i;
  logic [2:0] grant_o;
  sel_t       sel_o;
  logic       bus_valid_o;
  logic [2:0] ack_o;
  logic [2:0] abort_o;

  modport master (
    input  req_i,
    input  bus_ready_i,
    output grant_o,
    output sel_o,
    output bus_valid_o,
    output ack_o,
    output abort_o
  );

  modport slave (
    output req_i,
    output bus_ready_i,
    input  grant_o,
    input  sel_o,
    input  bus_valid_o,
    input  ack_o,
    input  abort_o
  );

endinterface

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
//   req_i   : request mask to arbitrate among
//   last_i  : index of the most recent grantee (0..2)
//   win_o   : one-hot winner, 000 when nothing is requested
//   found_o : at least one request present
// Search order starts just after last_i and wraps, so the previous grantee
// has the lowest priority.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  sel_t       last_i,
  output logic [2:0] win_o,
  output logic       found_o
);

  sel_t       cand [NUM_REQ];
  logic [2:0] cand_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi]     = rr_next(last_i, gi + 1);
    assign cand_hit[gi] = req_i[cand[gi]];
  end

  always_comb begin
    win_o   = 3'b000;
    found_o = |req_i;
    if (cand_hit[0]) begin
      win_o[cand[0]] = 1'b1;
    end else if (cand_hit[1]) begin
      win_o[cand[1]] = 1'b1;
    end else if (cand_hit[2]) begin
      win_o[cand[2]] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among instruction fetch (0),
// load/store (1) and debug/DMA (2). A grant is held until the bus reports
// ready or the watchdog expires; the next grant follows with no idle bubble.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.master (requests, ready, grant, select,
//            valid, ack, abort)
// Parameter TIMEOUT: BUSY cycles without ready before abort; 0 disables.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mem_port_arbiter_if.master  bus
);

  localparam int CNT_W    = $clog2(TIMEOUT + 1);
  // With the watchdog disabled CNT_W is zero; keep one dummy bit.
  localparam int CNT_BITS = (CNT_W < 1) ? 1 : CNT_W;

  arb_state_e          state_q;
  logic [2:0]          grant_q;
  sel_t                sel_q;
  sel_t                last_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic [2:0] pick_mask;
  logic [2:0] pick_win;
  logic       pick_found;
  sel_t       pick_sel_d;
  logic       timeout_hit;
  logic       xfer_end;

  // grant_q is zero in IDLE, so the same mask serves both the initial pick
  // and the end-of-transfer pick that excludes the finishing requester.
  assign pick_mask = bus.req_i & ~grant_q;

  rr_pick3 u_pick (
    .req_i   (pick_mask),
    .last_i  (last_q),
    .win_o   (pick_win),
    .found_o (pick_found)
  );

  assign pick_sel_d = onehot_to_sel(pick_win);

  if (TIMEOUT != 0) begin : g_wdog
    // Ready in the same cycle takes precedence over the watchdog.
    assign timeout_hit = (cnt_q == CNT_BITS'(TIMEOUT - 1)) & ~bus.bus_ready_i;
  end else begin : g_no_wdog
    assign timeout_hit = 1'b0;
  end

  assign xfer_end = bus.bus_ready_i | timeout_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      sel_q   <= SEL_REQ0;
      last_q  <= SEL_REQ2;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= BUSY;
            grant_q <= pick_win;
            sel_q   <= pick_sel_d;
            last_q  <= pick_sel_d;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (xfer_end) begin
            cnt_q <= '0;
            if (pick_found) begin
              grant_q <= pick_win;
              sel_q   <= pick_sel_d;
              last_q  <= pick_sel_d;
            end else begin
              // sel_q is left alone so the mux output stays stable in IDLE.
              state_q <= IDLE;
              grant_q <= 3'b000;
            end
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 3'b000;
        end
      endcase
    end
  end

  assign bus.grant_o     = grant_q;
  assign bus.sel_o       = sel_q;
  assign bus.bus_valid_o = (state_q == BUSY);
  assign bus.ack_o       = grant_q & {3{bus.bus_ready_i}};
  assign bus.abort_o     = grant_q & {3{timeout_hit}};

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.grant_o));
  a_sel_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.sel_o != 2'b11);
  a_valid_grant : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.bus_valid_o == |bus.grant_o);
  a_sel_matches : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.bus_valid_o |-> (bus.sel_o == onehot_to_sel(bus.grant_o)));
  a_ack_abort_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((|bus.ack_o) && (|bus.abort_o)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [2:0] ack;
    logic [2:0] abort;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  // Instance A has a short watchdog, instance B has it disabled.
  mem_port_arbiter #(.TIMEOUT(4)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(bus_a));
  mem_port_arbiter #(.TIMEOUT(0)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;
  string phase = "reset";

  exp_t exp_qa[$];
  exp_t exp_qb[$];

  // Reference model: owner index (-1 = none), last grantee, wait count,
  // held mux select. Index 0 models dut_a, index 1 models dut_b.
  int       m_owner [2];
  int       m_last  [2];
  int       m_wait  [2];
  int       m_sel   [2];
  int       m_tmo   [2];

  function automatic int rr_choose(input logic [2:0] mask, input int last);
    for (int o = 1; o <= 3; o++) begin
      int k;
      k = (last + o) % 3;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = 2;
      m_wait[d]  = 0;
      m_sel[d]   = 0;
    end
  endtask

  // Expected outputs for the cycle just started, then advance the model
  // across the coming rising edge.
  task automatic model_cycle(input int d, input logic rstn, input logic [2:0] req,
                             input logic rdy, output exp_t e);
    logic [2:0] g;
    logic       hit;
    int         w;
    e = '0;
    if (!rstn) return;
    g   = (m_owner[d] >= 0) ? 3'(1 << m_owner[d]) : 3'b000;
    hit = (m_tmo[d] != 0) && (m_owner[d] >= 0) && (m_wait[d] == m_tmo[d] - 1) && !rdy;
    e.grant = g;
    e.sel   = 2'(m_sel[d]);
    e.valid = (m_owner[d] >= 0);
    e.ack   = rdy ? g : 3'b000;
    e.abort = hit ? g : 3'b000;
    if (m_owner[d] < 0) begin
      w = rr_choose(req, m_last[d]);
      if (w >= 0) begin
        m_owner[d] = w; m_last[d] = w; m_sel[d] = w; m_wait[d] = 0;
      end
    end else if (rdy || hit) begin
      w = rr_choose(req & ~g, m_last[d]);
      m_wait[d] = 0;
      if (w >= 0) begin
        m_owner[d] = w; m_last[d] = w; m_sel[d] = w;
      end else begin
        m_owner[d] = -1;
      end
    end else begin
      m_wait[d]++;
    end
  endtask

  task automatic cycle(input logic rstn, input logic [2:0] req, input logic rdy);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst_n = rstn;
    bus_a.req_i = req;       bus_b.req_i = req;
    bus_a.bus_ready_i = rdy; bus_b.bus_ready_i = rdy;
    if (!rstn) model_reset();
    model_cycle(0, rstn, req, rdy, ea);
    model_cycle(1, rstn, req, rdy, eb);
    exp_qa.push_back(ea);
    exp_qb.push_back(eb);
  endtask

  task automatic check_one(input string name, input exp_t e, input exp_t act);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s phase=%s t=%0t got grant=%b sel=%b valid=%b ack=%b abort=%b expected grant=%b sel=%b valid=%b ack=%b abort=%b",
               name, phase, $time, act.grant, act.sel, act.valid, act.ack, act.abort,
               e.grant, e.sel, e.valid, e.ack, e.abort);
    end else if ((|e.ack) || (|e.abort)) begin
      $display("txn %s phase=%s t=%0t grant=%b sel=%b %s", name, phase, $time,
               e.grant, e.sel, (|e.ack) ? "ack" : "abort");
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the edge.
  always @(negedge clk) begin
    exp_t e, act;
    if (exp_qa.size() > 0) begin
      e = exp_qa.pop_front();
      act = {bus_a.grant_o, bus_a.sel_o, bus_a.bus_valid_o, bus_a.ack_o, bus_a.abort_o};
      check_one("dutA", e, act);
    end
    if (exp_qb.size() > 0) begin
      e = exp_qb.pop_front();
      act = {bus_b.grant_o, bus_b.sel_o, bus_b.bus_valid_o, bus_b.ack_o, bus_b.abort_o};
      check_one("dutB", e, act);
    end
  end

  initial begin
    m_tmo[0] = 4;
    m_tmo[1] = 0;
    model_reset();
    bus_a.req_i = 3'b000; bus_b.req_i = 3'b000;
    bus_a.bus_ready_i = 1'b0; bus_b.bus_ready_i = 1'b0;

    phase = "reset";
    repeat (3) cycle(1'b0, 3'b000, 1'b0);

    phase = "single_req0";
    cycle(1'b1, 3'b001, 1'b0);
    cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b1, 3'b000, 1'b1);
    repeat (2) cycle(1'b1, 3'b000, 1'b0);

    phase = "all_req_rr";
    repeat (8) cycle(1'b1, 3'b111, 1'b1);
    repeat (2) cycle(1'b1, 3'b000, 1'b0);

    phase = "timeout_req1";
    repeat (7) cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b1, 3'b000, 1'b1);
    repeat (2) cycle(1'b1, 3'b000, 1'b0);

    phase = "timeout_handoff";
    cycle(1'b1, 3'b010, 1'b0);
    repeat (6) cycle(1'b1, 3'b110, 1'b0);
    repeat (2) cycle(1'b1, 3'b000, 1'b1);

    phase = "ready_and_timeout";
    cycle(1'b1, 3'b001, 1'b0);
    repeat (3) cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b1, 3'b000, 1'b1);
    cycle(1'b1, 3'b000, 1'b0);

    phase = "drop_req";
    cycle(1'b1, 3'b100, 1'b0);
    repeat (2) cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b1, 3'b000, 1'b1);
    cycle(1'b1, 3'b000, 1'b0);

    phase = "reset_mid_busy";
    repeat (2) cycle(1'b1, 3'b010, 1'b0);
    cycle(1'b0, 3'b010, 1'b1);
    cycle(1'b0, 3'b000, 1'b0);
    cycle(1'b1, 3'b111, 1'b0);
    repeat (3) cycle(1'b1, 3'b111, 1'b1);
    cycle(1'b1, 3'b000, 1'b1);

    phase = "long_wait";
    cycle(1'b1, 3'b100, 1'b0);
    repeat (100) cycle(1'b1, 3'b000, 1'b0);
    cycle(1'b1, 3'b000, 1'b1);
    cycle(1'b1, 3'b000, 1'b0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      logic       rstn;
      logic [2:0] req;
      logic       rdy;
      rstn = ($urandom_range(0, 99) != 0);
      req  = 3'($urandom_range(0, 7));
      rdy  = ($urandom_range(0, 3) == 0);
      cycle(rstn, req, rdy);
    end
    cycle(1'b1, 3'b000, 1'b1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && (exp_qa.size() + exp_qb.size()) > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if ((exp_qa.size() + exp_qb.size()) != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations, required 0",
               exp_qa.size() + exp_qb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares one memory/bus port among three requesters: 0 = instruction fetch, 1 = load/store, 2 = debug/DMA. It drives the 2-bit select of the 32-bit 3:1 operand muxes that steer address, write data and write-enable onto the shared port. It holds each grant until the bus completes the transfer or a watchdog expires, and sequences the next grant back-to-back.

Parameters:
TIMEOUT, 16, max BUSY cycles without bus_ready_i before abort; 0 disables the watchdog.
CNT_W, $clog2(TIMEOUT+1) (localparam), watchdog counter width.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
req_i  input  3  per-requester request, level; bit k belongs to requester k.
bus_ready_i  input  1  shared port completes the current transfer this cycle.
grant_o  output  3  one-hot registered grant; 000 when idle.
sel_o  output  2  mux select: 00 = req 0, 01 = req 1, 10 = req 2; 11 is never driven.
bus_valid_o  output  1  transfer on the shared port is active.
ack_o  output  3  combinational: grant_o & {3{bus_ready_i}}.
abort_o  output  3  combinational: grant_o & {3{timeout_hit}}; timeout_hit = (TIMEOUT != 0) & (cnt == TIMEOUT-1) & ~bus_ready_i.

Behaviour:
- Reset (async, rst_ni = 0):
  - state = IDLE, grant_o = 000, sel_o = 00, bus_valid_o = 0, cnt = 0.
  - last_grant = 2, so requester 0 wins first after reset.
  - Reset asserted mid-transfer aborts silently: no ack_o or abort_o pulse; all outputs clear immediately.
- States: IDLE, BUSY.
- IDLE:
  - bus_valid_o = 0, grant_o = 000.
  - sel_o holds the last grantee so the mux output stays stable.
  - If req_i != 0 at a rising edge, pick the winner round-robin starting at (last_grant+1) mod 3 and go to BUSY.
  - In that same edge: grant_o, sel_o, bus_valid_o = 1 and last_grant are registered, and cnt = 0.
  - Latency: request seen at edge N gives grant visible after edge N (one cycle).
- BUSY:
  - grant_o and sel_o hold; cnt increments each cycle without bus_ready_i.
  - Dropping req_i while granted is ignored; the transfer is committed until ready or abort.
- End of transfer (bus_ready_i = 1, or timeout_hit = 1) at an edge:
  - The re-arbitration mask is req_i & ~grant_o, so the finishing requester is excluded from this pick.
  - If the mask is non-zero: stay in BUSY with the new round-robin winner, cnt = 0. This is a back-to-back grant with no bubble.
  - Otherwise go to IDLE.
  - bus_ready_i and timeout_hit in the same cycle: ready wins; ack_o pulses, abort_o stays 0.
- Round-robin: the priority order rotates after each grant. With all three requesting continuously, grants go 0, 1, 2, 0, ... with each held one transfer. No starvation.
- Invariants (checked by assertions):
  - grant_o is $onehot0.
  - sel_o != 11.
  - bus_valid_o == |grant_o.
  - sel_o encodes grant_o whenever bus_valid_o = 1.
  - ack_o and abort_o are never both non-zero.

Decomposition:
- Package mem_arb_pkg:
  - sel encodings SEL_REQ0 = 2'b00, SEL_REQ1 = 2'b01, SEL_REQ2 = 2'b10.
  - state enum arb_state_e {IDLE, BUSY}.
  - one-hot-to-sel conversion function.
- Sub-module rr_pick3: combinational. Inputs are the 3-bit request mask and 2-bit last_grant. Outputs are a one-hot winner and a found flag. Instantiated once and reused for the IDLE and end-of-transfer picks.

Test Plan:
1. Reset, then req_i = 001, ready after 2 cycles:
   - grant_o = 001 and sel_o = 00 one edge after the request.
   - ack_o = 001 in the ready cycle; then IDLE with grant_o = 000 and sel_o held at 00.
2. req_i = 111 held, bus_ready_i = 1 every cycle:
   - grant sequence 001, 010, 100, 001 on consecutive cycles.
   - sel_o = 00, 01, 10, 00; bus_valid_o stays 1 with no bubble.
3. TIMEOUT = 4, req_i = 010, bus_ready_i = 0:
   - abort_o = 010 in the 4th BUSY cycle, then IDLE.
   - With req_i = 110 instead, the next grant is 100.
4. Ready and timeout in the same cycle (cnt = TIMEOUT-1, bus_ready_i = 1):
   - ack_o = grant_o, abort_o = 000.
5. Requester drops req_i while granted:
   - grant held until ready.
   - Separately, rst_ni pulled low mid-BUSY: all outputs 000/00/0 immediately with no ack_o or abort_o pulse, and after release requester 0 wins first.
6. TIMEOUT = 0, ready withheld for 100 cycles:
   - no abort_o; grant held throughout.
